// File: rtl/btn_event_pkg.sv
// Shared state encodings, default timing and counter sizing for the button event generator.
// Combinational definitions only; no latency, no backpressure.
package btn_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_t;

  localparam int DEF_NUM_BTN       = 4;
  localparam int DEF_LONG_CYCLES   = 25_000_000;
  localparam int DEF_REPEAT_CYCLES = 5_000_000;

  // One spare bit above the largest terminal count keeps the saturating counter clear of all-ones.
  function automatic int cnt_width(input int long_cycles, input int repeat_cycles);
    int m;
    m = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/btn_event_fsm.sv
// Per-button event FSM: press/release/long/repeat pulses plus a held level.
// One edge from a sampled Btn change to the registered pulse; no backpressure, pulses are fire-and-forget.
module btn_event_fsm
  import btn_event_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Btn,
  output logic Press,
  output logic Release,
  output logic Long,
  output logic Repeat,
  output logic Held
);

  localparam int               CNT_W      = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] LONG_CNT   = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_CNT = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             armed;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      armed   <= 1'b0;
      Press   <= 1'b0;
      Release <= 1'b0;
      Long    <= 1'b0;
      Repeat  <= 1'b0;
      Held    <= 1'b0;
    end else begin
      Press   <= 1'b0;
      Release <= 1'b0;
      Long    <= 1'b0;
      Repeat  <= 1'b0;
      // A button held through reset stays ignored until it has been seen released once.
      if (!Btn) armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (Btn && armed) begin
            Press <= 1'b1;
            cnt   <= CNT_ONE;
            state <= ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          if (!Btn) begin
            Release <= 1'b1;
            cnt     <= '0;
            state   <= ST_IDLE;
          end else if (cnt == LONG_CNT) begin
            Long  <= 1'b1;
            Held  <= 1'b1;
            cnt   <= CNT_ONE;
            state <= ST_HELD;
          end else begin
            cnt <= cnt_inc(cnt);
          end
        end
        ST_HELD: begin
          if (!Btn) begin
            Release <= 1'b1;
            Held    <= 1'b0;
            cnt     <= '0;
            state   <= ST_IDLE;
          end else if (cnt == REPEAT_CNT) begin
            Repeat <= 1'b1;
            cnt    <= CNT_ONE;
          end else begin
            cnt <= cnt_inc(cnt);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          Held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_event_gen.sv
// Converts NUM_BTN debounced button levels into independent per-button event pulses.
// One edge from Btn change to pulse; no backpressure, every output is a registered pulse or level.
module button_event_gen
  import btn_event_pkg::*;
#(
  parameter int NUM_BTN       = DEF_NUM_BTN,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_BTN-1:0] Btn,
  output logic [NUM_BTN-1:0] Press,
  output logic [NUM_BTN-1:0] Release,
  output logic [NUM_BTN-1:0] Long,
  output logic [NUM_BTN-1:0] Repeat,
  output logic [NUM_BTN-1:0] Held
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_event_fsm #(
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_fsm (
      .Clk    (Clk),
      .Rst    (Rst),
      .Btn    (Btn[i]),
      .Press  (Press[i]),
      .Release(Release[i]),
      .Long   (Long[i]),
      .Repeat (Repeat[i]),
      .Held   (Held[i])
    );
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with LONG_CYCLES=8, REPEAT_CYCLES=4.
// Per-edge input table and hand-written expected pulse tables, compared every cycle.
module tb_button_event_gen;

  localparam int N_EDGES       = 120;
  localparam int RST_LOW_EDGE  = 101;  // Rst drops between edges 100 and 101
  localparam int RST_HIGH_EDGE = 103;  // Rst rises before edge 103

  logic       Clk;
  logic       Rst;
  logic [3:0] Btn;
  logic [3:0] Press, Release, Long, Repeat, Held;

  logic [3:0] btn_tab     [0:N_EDGES];
  logic [3:0] exp_press   [0:N_EDGES];
  logic [3:0] exp_release [0:N_EDGES];
  logic [3:0] exp_long    [0:N_EDGES];
  logic [3:0] exp_repeat  [0:N_EDGES];
  logic [3:0] exp_held    [0:N_EDGES];

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  button_event_gen #(
    .NUM_BTN      (4),
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Btn    (Btn),
    .Press  (Press),
    .Release(Release),
    .Long   (Long),
    .Repeat (Repeat),
    .Held   (Held)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_vec(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s cycle=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_vec({tag, "_press"},   Press,   4'b0000);
    check_vec({tag, "_release"}, Release, 4'b0000);
    check_vec({tag, "_long"},    Long,    4'b0000);
    check_vec({tag, "_repeat"},  Repeat,  4'b0000);
    check_vec({tag, "_held"},    Held,    4'b0000);
  endtask

  initial begin
    for (int n = 0; n <= N_EDGES; n++) begin
      btn_tab[n]     = 4'b0000;
      exp_press[n]   = 4'b0000;
      exp_release[n] = 4'b0000;
      exp_long[n]    = 4'b0000;
      exp_repeat[n]  = 4'b0000;
      exp_held[n]    = 4'b0000;
    end

    // Button levels sampled at each edge.
    for (int n = 1; n <= N_EDGES; n++) begin
      btn_tab[n][0] = (n <= 17) || (n >= 20 && n <= 23) || (n >= 60 && n <= 73);
      btn_tab[n][1] = (n >= 10 && n <= 12) || (n >= 60 && n <= 73);
      btn_tab[n][2] = (n >= 30 && n <= 49) || (n >= 60 && n <= 73) ||
                      (n >= 90 && n <= 109) || (n >= 112 && n <= 113);
      btn_tab[n][3] = (n >= 60 && n <= 73) || (n >= 80 && n <= 87);
    end

    // Btn[0] held through reset: ignored until low at 18/19, pressed at 20, released at 24.
    exp_press[20][0]   = 1'b1;
    exp_release[24][0] = 1'b1;
    // Btn[1] short press.
    exp_press[10][1]   = 1'b1;
    exp_release[13][1] = 1'b1;
    // Btn[2] long hold: Long at 38, Repeat at 42/46, release at 50 beats the repeat due then.
    exp_press[30][2]   = 1'b1;
    exp_long[38][2]    = 1'b1;
    exp_repeat[42][2]  = 1'b1;
    exp_repeat[46][2]  = 1'b1;
    exp_release[50][2] = 1'b1;
    for (int n = 38; n <= 49; n++) exp_held[n][2] = 1'b1;
    // All four together.
    exp_press[60]   = 4'b1111;
    exp_long[68]    = 4'b1111;
    exp_repeat[72]  = 4'b1111;
    exp_release[74] = 4'b1111;
    for (int n = 68; n <= 73; n++) exp_held[n] = 4'b1111;
    // Btn[3] released exactly at k+8: release wins, no Long.
    exp_press[80][3]   = 1'b1;
    exp_release[88][3] = 1'b1;
    // Btn[2] reaches HELD, then reset hits; afterwards held-through-reset is ignored.
    exp_press[90][2]   = 1'b1;
    exp_long[98][2]    = 1'b1;
    for (int n = 98; n <= 100; n++) exp_held[n][2] = 1'b1;
    exp_press[112][2]   = 1'b1;
    exp_release[114][2] = 1'b1;

    Rst = 1'b0;
    Btn = 4'b0001;
    repeat (2) @(negedge Clk);
    check_all_zero("reset");
    Rst = 1'b1;

    for (int n = 1; n <= N_EDGES; n++) begin
      if (n == RST_LOW_EDGE) begin
        Rst = 1'b0;
        #1;
        check_all_zero("async_rst");
      end
      if (n == RST_HIGH_EDGE) Rst = 1'b1;
      Btn = btn_tab[n];
      @(posedge Clk);
      @(negedge Clk);
      cyc = n;
      check_vec("press",   Press,   exp_press[n]);
      check_vec("release", Release, exp_release[n]);
      check_vec("long",    Long,    exp_long[n]);
      check_vec("repeat",  Repeat,  exp_repeat[n]);
      check_vec("held",    Held,    exp_held[n]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Sits directly downstream of the 4-button debouncer and consumes its clean, synchronous, stable button levels.
- Converts each level into single-cycle event pulses: press, release, long-press and auto-repeat. It also provides a held level.
- Feeds the control logic (menu/counter FSMs), so that logic never handles raw levels or timing.
- One independent event FSM and counter per button.

Parameters:
- NUM_BTN, 4, number of buttons (width of every per-button port).
- LONG_CYCLES, 25_000_000, clock cycles from Press to Long (0.5 s at 50 MHz); must be ≥ 2.
- REPEAT_CYCLES, 5_000_000, cycles between successive Repeat pulses once Long has fired; must be ≥ 1.
- CNT_W, $clog2(max(LONG_CYCLES,REPEAT_CYCLES))+1, counter width (derived, not overridden).

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- Btn  input  NUM_BTN  debounced button levels, 1 = pressed, already synchronous to Clk.
- Press  output  NUM_BTN  1-cycle pulse on press.
- Release  output  NUM_BTN  1-cycle pulse on release.
- Long  output  NUM_BTN  1-cycle pulse when a press has lasted LONG_CYCLES.
- Repeat  output  NUM_BTN  1-cycle pulse every REPEAT_CYCLES after Long while held.
- Held  output  NUM_BTN  level, high from Long until release.

Behaviour:
- Clock and reset: one clock (Clk); reset is asynchronous and active-low (Rst).
- Reset state:
  - Rst low immediately clears all outputs to 0, all FSMs to IDLE and all counters to 0.
  - The per-button armed bit is also cleared to 0. This is asynchronous and takes effect mid-operation too.
- Arming:
  - A button generates no events until Btn is first sampled 0 after reset; that sample sets armed = 1.
  - A button held through reset is therefore ignored until it is released and pressed again.
- Sample convention:
  - Edge k is the first rising edge where Btn[i] = 1 and the previous sample was 0 (armed = 1).
  - "Cycle k" is the clock period following edge k.
  - All outputs are registered, so each one changes exactly at a clock edge.
- Per-button FSM, state IDLE:
  - Btn rising → Press = 1 in cycle k only; counter set to 1; go to PRESSED.
- Per-button FSM, state PRESSED:
  - The counter increments each cycle.
  - Btn sampled 0 → Release pulse; counter cleared; go to IDLE; no Long.
  - Counter reaching LONG_CYCLES while Btn = 1 → Long pulse in cycle k+LONG_CYCLES; Held = 1 from that same cycle; counter reset to 1; go to HELD.
- Per-button FSM, state HELD:
  - The counter increments each cycle.
  - Each time the counter reaches REPEAT_CYCLES → Repeat pulse and counter reset to 1.
  - Btn sampled 0 → Release pulse; Held cleared in the same cycle; go to IDLE.
- Release priority: release always wins over Long or Repeat due on the same edge. No Long or Repeat is emitted on the release cycle.
- Pulse exclusivity: at most one of Press/Release/Long/Repeat is high per button per cycle.
- Cross-button independence: buttons never interact. Simultaneous events on several buttons appear in the same cycle.
- Counter saturation: counters never wrap. With legal parameters the count is reset before reaching 2^CNT_W − 1.
- Latency: Btn change to pulse is one edge.

Decomposition:
- Package btn_event_pkg holds:
  - FSM state encodings IDLE = 2'd0, PRESSED = 2'd1, HELD = 2'd2 (2'd3 is illegal and recovers to IDLE).
  - Default timing constants.
  - The CNT_W derivation function.
- Sub-module btn_event_fsm handles one button: Clk, Rst, Btn, and the five single-bit outputs, with the same parameters.
- The top level instantiates btn_event_fsm NUM_BTN times in a generate loop and contains no other logic.

Test Plan (LONG_CYCLES = 8, REPEAT_CYCLES = 4):
- Rst released with Btn[0] = 1 held → no Press[0]. Btn[0] then low for 2 cycles and high at edge 20 → Press[0] = 1 in cycle 20 only.
- Btn[1] high at edge 10 and low at edge 13 → Press[1] in cycle 10, Release[1] in cycle 13. Long[1], Repeat[1] and Held[1] stay 0.
- Btn[2] high at edge 30, held to edge 50 →
  - Press in cycle 30.
  - Long and Held rising in cycle 38.
  - Repeat in cycles 42, 46 and 50 are suppressed at 50 (release wins); only 42 and 46 occur.
  - Release and Held fall in cycle 50.
- Btn = 4'b1111 at a single edge → Press = 4'b1111 in the same cycle. Later Long = 4'b1111 in the same cycle.
- Btn[3] released exactly at edge k+8 → Release[3] only, no Long[3], Held[3] stays 0.
- Rst pulsed low in HELD state between edges with Btn[2] = 1 → all outputs 0 immediately. After Rst rises with Btn[2] still 1 → no events until a release and re-press.
